rsa_io_sequencer: RTL and testbench

RSA_IO_SEQUENCER -- requirements
Module: rsa_io_sequencer

---
 rtl/rsa_pkg.sv | 28 ++
 rtl/rx_word_packer.sv | 70 +++++++
 rtl/rsa_io_sequencer.sv | 158 +++++++++++++++
 tb/tb_rsa_io_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// -----------------------------------------------------------------------------
// rsa_pkg
// Shared definitions for the RSA byte-to-word I/O sequencer.
//   WORD_W / BYTE_W    : plaintext word width and UART byte width
//   BYTES_PER_WORD     : bytes packed into one word
//   EOT_DEFAULT        : default end-of-transmission byte
//   PAD_DEFAULT        : default fill byte for a partial final word
//   seq_state_t        : sequencer FSM states
// -----------------------------------------------------------------------------
package rsa_pkg;

   localparam int WORD_W         = 32;
   localparam int BYTE_W         = 8;
   localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

   localparam logic [BYTE_W-1:0] EOT_DEFAULT = 8'h04;
   localparam logic [BYTE_W-1:0] PAD_DEFAULT = 8'h00;

   typedef enum logic [2:0] {
      ST_COLLECT,
      ST_CORE_START,
      ST_CORE_WAIT,
      ST_SEND,
      ST_TX_WAIT,
      ST_EOT
   } seq_state_t;

endpackage

// File: rtl/rx_word_packer.sv
// -----------------------------------------------------------------------------
// rx_word_packer
// Packs accepted UART bytes MSB-first into a 32-bit word. Byte 0 lands in
// word[31:24], byte 3 in word[7:0]. An EOT byte arriving mid-word fills the
// remaining byte lanes with PAD_CHAR and returns the counter to 0.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   accept       : one-cycle strobe, byte_in is consumed this cycle
//   byte_in      : candidate byte (the UART receive data)
//   word         : packed word (drives core_data)
//   count        : number of bytes already placed in the current word
//   byte_is_eot  : byte_in equals EOT_CHAR
// -----------------------------------------------------------------------------
module rx_word_packer
   import rsa_pkg::*;
#(
   parameter logic [BYTE_W-1:0] EOT_CHAR = EOT_DEFAULT,
   parameter logic [BYTE_W-1:0] PAD_CHAR = PAD_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              accept,
   input  logic [BYTE_W-1:0] byte_in,
   output logic [WORD_W-1:0] word,
   output logic [1:0]        count,
   output logic              byte_is_eot
);

   logic [WORD_W-1:0] word_next;
   logic [1:0]        count_next;

   assign byte_is_eot = (byte_in == EOT_CHAR);

   // An EOT at count 0 leaves the word untouched: no word will be issued, so
   // the last plaintext stays visible on core_data.
   always_comb begin
      word_next  = word;
      count_next = count;
      if (accept) begin
         if (byte_is_eot) begin
            if (count != 2'd0) begin
               for (int i = 0; i < BYTES_PER_WORD; i++) begin
                  if (2'(i) >= count) begin
                     word_next[WORD_W-BYTE_W*(i+1) +: BYTE_W] = PAD_CHAR;
                  end
               end
            end
            count_next = 2'd0;
         end else begin
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
               if (2'(i) == count) begin
                  word_next[WORD_W-BYTE_W*(i+1) +: BYTE_W] = byte_in;
               end
            end
            count_next = count + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word  <= '0;
         count <= 2'd0;
      end else begin
         word  <= word_next;
         count <= count_next;
      end
   end

endmodule

// File: rtl/rsa_io_sequencer.sv
// -----------------------------------------------------------------------------
// rsa_io_sequencer
// Collects UART bytes into 32-bit words, hands each word to the RSA core,
// waits for the encrypted result and passes it to the output packer. An EOT
// byte terminates the message, padding a partial final word.
// Optional feature macro: RSA_SEQ_WORDCNT_EN adds a saturating 16-bit
// word_count output counting issued words.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   rx_readable   : UART holds an unread byte, rx_data valid
//   rx_used_tick  : one-cycle pulse, byte consumed
//   core_start    : one-cycle pulse, encrypt core_data
//   core_data     : packed plaintext word
//   core_done     : one-cycle pulse, core_result valid
//   core_result   : encrypted word
//   word_ready    : one-cycle pulse to the output packer
//   data_out      : latched encrypted word
//   sending_word  : output packer busy
//   busy          : sequencer not idle
//   eot_seen      : message terminated
//   word_count    : words issued (only with RSA_SEQ_WORDCNT_EN)
// -----------------------------------------------------------------------------
module rsa_io_sequencer
   import rsa_pkg::*;
#(
   parameter logic [BYTE_W-1:0] EOT_CHAR = EOT_DEFAULT,
   parameter logic [BYTE_W-1:0] PAD_CHAR = PAD_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_readable,
   input  logic [BYTE_W-1:0] rx_data,
   output logic              rx_used_tick,
   output logic              core_start,
   output logic [WORD_W-1:0] core_data,
   input  logic              core_done,
   input  logic [WORD_W-1:0] core_result,
   output logic              word_ready,
   output logic [WORD_W-1:0] data_out,
   input  logic              sending_word,
   output logic              busy,
   output logic              eot_seen
`ifdef RSA_SEQ_WORDCNT_EN
   ,
   output logic [15:0]       word_count
`endif
);

   seq_state_t state;
   seq_state_t state_next;
   logic       accept;
   logic       byte_is_eot;
   logic [1:0] count;
   logic       eot_pending;
   logic       tx_first;

   // A byte is taken only while collecting (or idle after EOT). The cycle
   // after a take is skipped because the UART needs a cycle to drop
   // rx_readable after seeing rx_used_tick.
   assign accept = ((state == ST_COLLECT) || (state == ST_EOT))
                   && rx_readable && !rx_used_tick;

   rx_word_packer #(
      .EOT_CHAR (EOT_CHAR),
      .PAD_CHAR (PAD_CHAR)
   ) u_packer (
      .clk         (clk),
      .rst         (rst),
      .accept      (accept),
      .byte_in     (rx_data),
      .word        (core_data),
      .count       (count),
      .byte_is_eot (byte_is_eot)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_COLLECT;
      end else begin
         state <= state_next;
      end
   end

   // A byte received in EOT is treated exactly like one received in COLLECT.
   always_comb begin
      state_next = state;
      case (state)
         ST_COLLECT, ST_EOT: begin
            if (accept) begin
               if (byte_is_eot) begin
                  state_next = (count == 2'd0) ? ST_EOT : ST_CORE_START;
               end else if (count == 2'd3) begin
                  state_next = ST_CORE_START;
               end else begin
                  state_next = ST_COLLECT;
               end
            end
         end
         ST_CORE_START: state_next = ST_CORE_WAIT;
         ST_CORE_WAIT: begin
            if (core_done) begin
               state_next = ST_SEND;
            end
         end
         ST_SEND: state_next = ST_TX_WAIT;
         ST_TX_WAIT: begin
            if (!tx_first && !sending_word) begin
               state_next = eot_pending ? ST_EOT : ST_COLLECT;
            end
         end
         default: state_next = ST_COLLECT;
      endcase
   end

   always_comb begin
      core_start = (state == ST_CORE_START);
      word_ready = (state == ST_SEND);
      eot_seen   = (state == ST_EOT);
      busy       = !(((state == ST_COLLECT) && (count == 2'd0)) || (state == ST_EOT));
   end

   // tx_first masks sending_word on the first TX_WAIT cycle, since the
   // output packer has not yet had a chance to raise it after word_ready.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_used_tick <= 1'b0;
         tx_first     <= 1'b0;
         eot_pending  <= 1'b0;
         data_out     <= '0;
      end else begin
         rx_used_tick <= accept;
         tx_first     <= (state == ST_SEND);
         if (accept && byte_is_eot && (count != 2'd0)) begin
            eot_pending <= 1'b1;
         end else if (state == ST_EOT) begin
            eot_pending <= 1'b0;
         end
         if ((state == ST_CORE_WAIT) && core_done) begin
            data_out <= core_result;
         end
      end
   end

`ifdef RSA_SEQ_WORDCNT_EN
   // A new message starts when a byte pulls the FSM out of EOT, so the count
   // restarts there.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word_count <= 16'h0000;
      end else if ((state == ST_EOT) && (state_next != ST_EOT)) begin
         word_count <= 16'h0000;
      end else if ((state == ST_SEND) && (word_count != 16'hFFFF)) begin
         word_count <= word_count + 16'h0001;
      end
   end
`endif

endmodule

// File: tb/tb_rsa_io_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rsa_io_sequencer
// Directed self-checking bench for rsa_io_sequencer. A simple UART model
// holds rx_readable until it sees rx_used_tick and drops it one cycle later;
// the RSA core and output packer are driven by hand from the main sequence.
// -----------------------------------------------------------------------------
module tb_rsa_io_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_readable = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_used_tick;
   logic        core_start;
   logic [31:0] core_data;
   logic        core_done = 1'b0;
   logic [31:0] core_result = 32'h0;
   logic        word_ready;
   logic [31:0] data_out;
   logic        sending_word = 1'b0;
   logic        busy;
   logic        eot_seen;
`ifdef RSA_SEQ_WORDCNT_EN
   logic [15:0] word_count;
`endif

   int totalChecks = 0;
   int badChecks   = 0;

   int          tickCount      = 0;
   int          coreStartCount = 0;
   int          wordReadyCount = 0;
   logic [31:0] coreDataAtStart = 32'h0;
   logic [31:0] dataOutAtReady  = 32'h0;

   rsa_io_sequencer dut (
      .clk          (clk),
      .rst          (rst),
      .rx_readable  (rx_readable),
      .rx_data      (rx_data),
      .rx_used_tick (rx_used_tick),
      .core_start   (core_start),
      .core_data    (core_data),
      .core_done    (core_done),
      .core_result  (core_result),
      .word_ready   (word_ready),
      .data_out     (data_out),
      .sending_word (sending_word),
      .busy         (busy),
      .eot_seen     (eot_seen)
`ifdef RSA_SEQ_WORDCNT_EN
      ,
      .word_count   (word_count)
`endif
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Pulse monitor on the falling edge, away from the updates at the rising edge.
   always @(negedge clk) begin
      if (rx_used_tick) tickCount++;
      if (core_start) begin
         coreStartCount++;
         coreDataAtStart = core_data;
      end
      if (word_ready) begin
         wordReadyCount++;
         dataOutAtReady = data_out;
      end
   end

   // Hard time limit so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      totalChecks++;
      if (observed !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // UART model: present a byte, wait for the tick, drop one cycle later.
   task automatic applyStimulus(input logic [7:0] b);
      int waited = 0;
      rx_readable = 1'b1;
      rx_data     = b;
      while (rx_used_tick !== 1'b1 && waited < 50) begin
         @(posedge clk);
         #1;
         waited++;
      end
      if (rx_used_tick !== 1'b1) begin
         checkOutput("rx_tick_timeout", 32'(rx_used_tick), 32'd1);
      end
      @(posedge clk);
      #1;
      rx_readable = 1'b0;
   endtask

   task automatic pulseCoreDone(input logic [31:0] result);
      core_done   = 1'b1;
      core_result = result;
      cycles(1);
      core_done   = 1'b0;
   endtask

   task automatic applyReset();
      rx_readable  = 1'b0;
      core_done    = 1'b0;
      sending_word = 1'b0;
      rst = 1'b0;
      cycles(2);
      rst = 1'b1;
      cycles(1);
   endtask

   initial begin
      int startBase;
      int readyBase;
      int tickBase;

      // ---------------- reset state ----------------
      #2 rst = 1'b0;
      cycles(2);
      checkOutput("rst_core_data", core_data, 32'h0);
      checkOutput("rst_data_out", data_out, 32'h0);
      checkOutput("rst_rx_tick", 32'(rx_used_tick), 32'd0);
      checkOutput("rst_core_start", 32'(core_start), 32'd0);
      checkOutput("rst_word_ready", 32'(word_ready), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_eot_seen", 32'(eot_seen), 32'd0);
`ifdef RSA_SEQ_WORDCNT_EN
      checkOutput("rst_word_count", 32'(word_count), 32'd0);
`endif
      rst = 1'b1;
      cycles(1);

      // ---------------- stray core_done ignored ----------------
      pulseCoreDone(32'h12345678);
      cycles(1);
      checkOutput("stray_done_data_out", data_out, 32'h0);
      checkOutput("stray_done_busy", 32'(busy), 32'd0);

      // ---------------- full word ----------------
      startBase = coreStartCount;
      readyBase = wordReadyCount;
      applyStimulus(8'h55);
      applyStimulus(8'h33);
      applyStimulus(8'h0F);
      applyStimulus(8'h59);
      cycles(2);
      checkOutput("word_core_start_cnt", 32'(coreStartCount - startBase), 32'd1);
      checkOutput("word_core_data", coreDataAtStart, 32'h55330F59);
      checkOutput("word_core_data_stable", core_data, 32'h55330F59);
      checkOutput("word_busy_wait", 32'(busy), 32'd1);
      pulseCoreDone(32'hDEADBEEF);
      sending_word = 1'b1;
      cycles(3);
      checkOutput("word_busy_tx", 32'(busy), 32'd1);
      checkOutput("word_ready_cnt", 32'(wordReadyCount - readyBase), 32'd1);
      checkOutput("word_data_out", dataOutAtReady, 32'hDEADBEEF);
      sending_word = 1'b0;
      cycles(3);
      checkOutput("word_idle_busy", 32'(busy), 32'd0);
      checkOutput("word_data_out_held", data_out, 32'hDEADBEEF);
      checkOutput("word_eot_seen", 32'(eot_seen), 32'd0);

      // ---------------- partial word with EOT ----------------
      applyReset();
      startBase = coreStartCount;
      readyBase = wordReadyCount;
      applyStimulus(8'h55);
      applyStimulus(8'h33);
      applyStimulus(8'h04);
      cycles(1);
      checkOutput("pad_core_start_cnt", 32'(coreStartCount - startBase), 32'd1);
      checkOutput("pad_core_data", coreDataAtStart, 32'h55330000);
      checkOutput("pad_eot_early", 32'(eot_seen), 32'd0);
      pulseCoreDone(32'h0BADF00D);
      cycles(3);
      checkOutput("pad_ready_cnt", 32'(wordReadyCount - readyBase), 32'd1);
      checkOutput("pad_data_out", dataOutAtReady, 32'h0BADF00D);
      checkOutput("pad_eot_seen", 32'(eot_seen), 32'd1);
      checkOutput("pad_busy", 32'(busy), 32'd0);
`ifdef RSA_SEQ_WORDCNT_EN
      checkOutput("pad_word_count", 32'(word_count), 32'd1);
`endif

      // ---------------- lone EOT, then a new byte ----------------
      applyReset();
      startBase = coreStartCount;
      applyStimulus(8'h04);
      checkOutput("eot_only_seen", 32'(eot_seen), 32'd1);
      cycles(3);
      checkOutput("eot_only_no_start", 32'(coreStartCount - startBase), 32'd0);
      checkOutput("eot_only_sticky", 32'(eot_seen), 32'd1);
      checkOutput("eot_only_busy", 32'(busy), 32'd0);
      applyStimulus(8'h41);
      checkOutput("eot_cleared", 32'(eot_seen), 32'd0);
      checkOutput("eot_next_busy", 32'(busy), 32'd1);

      // ---------------- rx held during CORE_WAIT ----------------
      applyReset();
      startBase = coreStartCount;
      readyBase = wordReadyCount;
      applyStimulus(8'h11);
      applyStimulus(8'h22);
      applyStimulus(8'h33);
      applyStimulus(8'h44);
      rx_readable = 1'b1;
      rx_data     = 8'hA1;
      tickBase    = tickCount;
      cycles(5);
      checkOutput("hold_no_tick", 32'(tickCount - tickBase), 32'd0);
      checkOutput("hold_core_data", core_data, 32'h11223344);
      pulseCoreDone(32'hCAFEF00D);
      applyStimulus(8'hA1);
      applyStimulus(8'hB2);
      applyStimulus(8'hC3);
      applyStimulus(8'hD4);
      checkOutput("hold_tick_per_byte", 32'(tickCount - tickBase), 32'd4);
      checkOutput("hold_first_data_out", dataOutAtReady, 32'hCAFEF00D);
      checkOutput("hold_second_core_data", coreDataAtStart, 32'hA1B2C3D4);
      pulseCoreDone(32'h13579BDF);
      cycles(3);
      checkOutput("hold_ready_cnt", 32'(wordReadyCount - readyBase), 32'd2);
      checkOutput("hold_start_cnt", 32'(coreStartCount - startBase), 32'd2);

      // ---------------- reset during CORE_WAIT ----------------
      readyBase = wordReadyCount;
      applyStimulus(8'h01);
      applyStimulus(8'h02);
      applyStimulus(8'h03);
      applyStimulus(8'h05);
      cycles(1);
      rx_readable = 1'b1;
      rx_data     = 8'h9A;
      rst = 1'b0;
      #1;
      checkOutput("midrst_core_data", core_data, 32'h0);
      checkOutput("midrst_data_out", data_out, 32'h0);
      checkOutput("midrst_busy", 32'(busy), 32'd0);
`ifdef RSA_SEQ_WORDCNT_EN
      checkOutput("midrst_word_count", 32'(word_count), 32'd0);
`endif
      cycles(1);
      pulseCoreDone(32'h77777777);
      rst = 1'b1;
      #1;
      checkOutput("midrst_release_tick", 32'(rx_used_tick), 32'd0);
      applyStimulus(8'h9A);
      applyStimulus(8'hBC);
      applyStimulus(8'hDE);
      applyStimulus(8'hF0);
      cycles(1);
      checkOutput("midrst_no_ready", 32'(wordReadyCount - readyBase), 32'd0);
      checkOutput("midrst_data_out_zero", data_out, 32'h0);
      checkOutput("midrst_repack", coreDataAtStart, 32'h9ABCDEF0);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
